// File: rtl/keccak_padder.sv
// keccak_padder: packs 32-bit message words into SHA-3 rate blocks, applies 0x06..0x80 padding.
// Define KECCAK_PADDER_BYTECOUNT_EN to add the saturating msg_len byte counter output.
module keccak_padder #(
    parameter int C_SHA3_SIZE = 224,
    localparam int R      = 1600 - 2 * C_SHA3_SIZE,
    localparam int RB     = R / 8,
    localparam int RW     = RB / 4,
    localparam int WIDX_W = $clog2(RW)
) (
    input  logic          S_AXI_ACLK,
    input  logic          S_AXI_ARESETN,
    input  logic          in_clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_data,
    input  logic          in_last,
    input  logic [1:0]    in_bytes,
    output logic          block_valid,
    input  logic          block_ready,
    output logic [R-1:0]  block_data,
    output logic          block_last
`ifdef KECCAK_PADDER_BYTECOUNT_EN
    ,
    output logic [31:0]   msg_len
`endif
);

    // state | meaning
    // FILL  | accepting message words into the block register
    // OUT   | block presented to the core, held until block_ready
    // DONE  | final block delivered; waits for in_clear
    typedef enum logic [1:0] {
        FILL = 2'd0,
        OUT  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [WIDX_W-1:0]   widx, widx_nxt;
    logic [R-1:0]        blk, blk_nxt;
    logic                last_q, last_nxt;
    logic [31:0]         word_fmt;
    logic                accept;

    assign in_ready    = (state == FILL);
    assign block_valid = (state == OUT);
    assign block_data  = blk;
    assign block_last  = last_q;
    assign accept      = in_valid & in_ready;

    // Byte-reverse into lane order; on the last word drop unused bytes and place 0x06 right after.
    always_comb begin
        word_fmt = '0;
        for (int k = 0; k < 4; k++) begin
            if (!in_last || (k < int'(in_bytes))) begin
                word_fmt[8*k +: 8] = in_data[31-8*k -: 8];
            end else if (k == int'(in_bytes)) begin
                word_fmt[8*k +: 8] = 8'h06;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        widx_nxt  = widx;
        blk_nxt   = blk;
        last_nxt  = last_q;
        if (in_clear) begin
            state_nxt = FILL;
            widx_nxt  = '0;
            blk_nxt   = '0;
            last_nxt  = 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        blk_nxt[int'(widx)*32 +: 32] = word_fmt;
                        if (in_last) begin
                            blk_nxt[R-1 -: 8] = blk_nxt[R-1 -: 8] | 8'h80;
                            last_nxt  = 1'b1;
                            state_nxt = OUT;
                        end else if (widx == WIDX_W'(RW - 1)) begin
                            last_nxt  = 1'b0;
                            state_nxt = OUT;
                        end else begin
                            widx_nxt = widx + 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (block_ready) begin
                        blk_nxt   = '0;
                        widx_nxt  = '0;
                        last_nxt  = 1'b0;
                        state_nxt = last_q ? DONE : FILL;
                    end
                end
                DONE: begin
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state  <= FILL;
            widx   <= '0;
            blk    <= '0;
            last_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            widx   <= widx_nxt;
            blk    <= blk_nxt;
            last_q <= last_nxt;
        end
    end

`ifdef KECCAK_PADDER_BYTECOUNT_EN
    logic [31:0] len_q;
    logic [32:0] len_sum;

    always_comb begin
        len_sum = {1'b0, len_q} + (in_last ? {31'b0, in_bytes} : 33'd4);
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            len_q <= '0;
        end else if (in_clear) begin
            len_q <= '0;
        end else if (accept) begin
            len_q <= len_sum[32] ? 32'hFFFF_FFFF : len_sum[31:0];
        end
    end

    assign msg_len = len_q;
`endif

endmodule

// File: tb/tb_keccak_padder.sv
// Self-checking bench for keccak_padder (SHA3-224): message table + model scoreboard + corner sequences.
module tb_keccak_padder;

    localparam int SZ = 224;
    localparam int R  = 1600 - 2 * SZ;
    localparam int RB = R / 8;
    localparam int RW = RB / 4;

    logic          clk;
    logic          rst_n;
    logic          in_clear;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          in_last;
    logic [1:0]    in_bytes;
    logic          block_valid;
    logic          block_ready;
    logic [R-1:0]  block_data;
    logic          block_last;
`ifdef KECCAK_PADDER_BYTECOUNT_EN
    logic [31:0]   msg_len;
`endif

    keccak_padder #(.C_SHA3_SIZE(SZ)) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .in_clear     (in_clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_bytes     (in_bytes),
        .block_valid  (block_valid),
        .block_ready  (block_ready),
        .block_data   (block_data),
        .block_last   (block_last)
`ifdef KECCAK_PADDER_BYTECOUNT_EN
        ,
        .msg_len      (msg_len)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [R-1:0] data;
        logic         last;
    } blk_t;

    typedef struct {
        int          len;
        logic [7:0]  seed;
        string       txt;
        int          exp_blocks;
    } msg_t;

    blk_t exp_q[$];
    int   n_vec    = 0;
    int   n_err    = 0;
    int   n_blocks = 0;
    int   rdy_mode = 0;  // 0 random, 1 held low, 2 held high

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_blk(input string name, input logic [R-1:0] act, input logic [R-1:0] exp);
        int first;
        n_vec++;
        if (act !== exp) begin
            n_err++;
            first = 0;
            for (int j = RB - 1; j >= 0; j--) begin
                if (act[8*j +: 8] !== exp[8*j +: 8]) first = j;
            end
            $display("FAIL %s: byte %0d got %0h expected %0h", name, first,
                     act[8*first +: 8], exp[8*first +: 8]);
        end
    endtask

    function automatic msg_t mk(input int len, input logic [7:0] seed, input string txt, input int nb);
        msg_t m;
        m.len = len;
        m.seed = seed;
        m.txt = txt;
        m.exp_blocks = nb;
        return m;
    endfunction

    function automatic logic [7:0] mbyte(input msg_t m, input int i);
        if (m.txt.len() > 0) return m.txt[i];
        return 8'(int'(m.seed) + i);
    endfunction

    // Reference SHA-3 padding: message, 0x06, zero fill to a rate multiple, 0x80 on the final byte.
    task automatic push_expected(input msg_t m);
        int nb;
        nb = m.len / RB + 1;
        for (int b = 0; b < nb; b++) begin
            blk_t e;
            e.data = '0;
            for (int j = 0; j < RB; j++) begin
                int i;
                logic [7:0] v;
                i = b * RB + j;
                if (i < m.len) v = mbyte(m, i);
                else if (i == m.len) v = 8'h06;
                else v = 8'h00;
                if (b == nb - 1 && j == RB - 1) v = v | 8'h80;
                e.data[8*j +: 8] = v;
            end
            e.last = (b == nb - 1);
            exp_q.push_back(e);
        end
    endtask

    initial begin
        block_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                1: block_ready = 1'b0;
                2: block_ready = 1'b1;
                default: block_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    logic [R-1:0] held;
    logic         held_v = 1'b0;

    always @(negedge clk) begin
        if (rst_n && !in_clear && block_valid) begin
            if (held_v) check_blk("block_data_stable", block_data, held);
            if (block_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_block", 64'd1, 64'd0);
                end else begin
                    blk_t e;
                    e = exp_q.pop_front();
                    check_blk("block_data", block_data, e.data);
                    check("block_last", block_last, e.last);
                end
                n_blocks++;
                held_v = 1'b0;
            end else begin
                held   = block_data;
                held_v = 1'b1;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the word is accepted.
    task automatic send_word(input logic [31:0] d, input logic l, input logic [1:0] nb);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_bytes = nb;
        while (!in_ready && t < 500) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) check("in_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drive_msg(input msg_t m);
        int nfull;
        int wcnt;
        nfull = m.len / 4;
        wcnt  = 0;
        push_expected(m);
        for (int w = 0; w <= nfull; w++) begin
            logic [31:0] d;
            logic        l;
            logic [1:0]  nb;
            l  = (w == nfull);
            nb = l ? 2'(m.len % 4) : 2'd0;
            for (int k = 0; k < 4; k++) begin
                d[31-8*k -: 8] = (l && k >= int'(nb)) ? 8'h20 : mbyte(m, 4*w + k);
            end
            send_word(d, l, nb);
            wcnt++;
            check("block_valid_after_word", block_valid, l || (wcnt % RW == 0));
            if (block_valid) check("in_ready_in_out", in_ready, 1'b0);
        end
`ifdef KECCAK_PADDER_BYTECOUNT_EN
        check("msg_len", msg_len, m.len);
`endif
    endtask

    task automatic finish_msg(input msg_t m, input int n0);
        int t;
        t = 0;
        while (n_blocks < n0 + m.exp_blocks && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("blocks_delivered", n_blocks - n0, m.exp_blocks);
        check("in_ready_done", in_ready, 1'b0);
        check("block_valid_done", block_valid, 1'b0);
        in_clear = 1'b1;
        @(posedge clk);
        #1;
        in_clear = 1'b0;
        check("in_ready_after_clear", in_ready, 1'b1);
    endtask

    task automatic run_msg(input msg_t m);
        int n0;
        n0 = n_blocks;
        drive_msg(m);
        finish_msg(m, n0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        msg_t tbl[5];
        msg_t m;
        int   n0;

        tbl[0] = mk(0,   8'h00, "",            1);
        tbl[1] = mk(11,  8'h00, "Hello World", 1);
        tbl[2] = mk(143, 8'h10, "",            1);
        tbl[3] = mk(144, 8'h00, "",            2);
        tbl[4] = mk(290, 8'h55, "",            3);

        rst_n    = 1'b0;
        in_clear = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        in_bytes = '0;
        #3;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_block_valid", block_valid, 1'b0);
        check("rst_block_last", block_last, 1'b0);
        check_blk("rst_block_data", block_data, '0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_msg(tbl[i]);

        // Backpressure: block held for 5 cycles while a word is offered
        rdy_mode = 1;
        m  = mk(10, 8'h30, "", 1);
        n0 = n_blocks;
        drive_msg(m);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = 32'hDEADBEEF;
            in_last  = 1'b0;
            in_bytes = 2'd0;
            @(negedge clk);
            check("bp_block_valid", block_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        finish_msg(m, n0);

        // Clear in OUT together with block_ready: block is dropped
        rdy_mode = 1;
        n0 = n_blocks;
        send_word(32'h41424344, 1'b0, 2'd0);
        send_word(32'h45464748, 1'b1, 2'd1);
        check("clr_pre_valid", block_valid, 1'b1);
        @(posedge clk);
        #1;
        in_clear = 1'b1;
        rdy_mode = 2;
        @(posedge clk);
        #1;
        in_clear = 1'b0;
        check("clr_block_valid", block_valid, 1'b0);
        check("clr_in_ready", in_ready, 1'b1);
        check_blk("clr_block_data", block_data, '0);
        check("clr_not_delivered", n_blocks - n0, 0);
        rdy_mode = 0;
        run_msg(tbl[1]);

        // Async reset mid-FILL
        send_word(32'h11223344, 1'b0, 2'd0);
        send_word(32'h55667788, 1'b0, 2'd0);
        check("fill_partial_data", block_data[63:0], 64'h8877665544332211);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1'b1);
        check("arst_block_valid", block_valid, 1'b0);
        check("arst_block_last", block_last, 1'b0);
        check_blk("arst_block_data", block_data, '0);
`ifdef KECCAK_PADDER_BYTECOUNT_EN
        check("arst_msg_len", msg_len, 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_msg(tbl[2]);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
